// File: rtl/wb_arb_xbar.sv
// Round-robin arbitrated Wishbone interconnect: NM masters share one routed path to NS slaves.
// Optional macro WB_ARB_XBAR_TIMEOUT_EN adds a watchdog that errors out transfers a slave never answers.
module wb_arb_xbar #(
    parameter int NM      = 2,
    parameter int NS      = 3,
    parameter int MSK     = 24,
    parameter int AW      = 32,
    parameter int DW      = 128,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NM*AW-1:0]     s_wb_adr,
    input  logic [NM*(DW/8)-1:0] s_wb_sel,
    input  logic [NM-1:0]        s_wb_we,
    input  logic [NM*DW-1:0]     s_wb_dat_i,
    input  logic [NM-1:0]        s_wb_cyc,
    input  logic [NM-1:0]        s_wb_stb,
    output logic [NM*DW-1:0]     s_wb_dat_o,
    output logic [NM-1:0]        s_wb_ack,
    output logic [NM-1:0]        s_wb_err,
    output logic [NS*AW-1:0]     m_wb_adr,
    output logic [NS*(DW/8)-1:0] m_wb_sel,
    output logic [NS-1:0]        m_wb_we,
    output logic [NS*DW-1:0]     m_wb_dat_o,
    output logic [NS-1:0]        m_wb_cyc,
    output logic [NS-1:0]        m_wb_stb,
    input  logic [NS*DW-1:0]     m_wb_dat_i,
    input  logic [NS-1:0]        m_wb_ack,
    input  logic [NS-1:0]        m_wb_err
);
    localparam int SW  = DW / 8;
    localparam int IW  = AW - MSK;
    localparam int IWP = IW + 1;
    localparam int GW  = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [IW:0] NS_LIM = IWP'(NS);

    typedef enum logic [0:0] { ST_IDLE = 1'b0, ST_BUSY = 1'b1 } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last;
    logic [GW-1:0]   w_hi_pick;
    logic [GW-1:0]   w_lo_pick;
    logic [GW-1:0]   w_arb_pick;
    logic            w_hi_found;
    logic            w_arb_found;
    logic            w_busy;

    logic [AW-1:0]   w_g_adr;
    logic [SW-1:0]   w_g_sel;
    logic            w_g_we;
    logic [DW-1:0]   w_g_dat;
    logic            w_g_cyc;
    logic            w_g_stb;
    logic [IW-1:0]   w_idx;
    logic            w_mapped;

    logic [DW-1:0]   w_sl_dat;
    logic            w_sl_ack;
    logic            w_sl_err;

    logic            w_route;
    logic            w_fwd;
    logic [DW-1:0]   w_resp_dat;
    logic            w_resp_ack;
    logic            w_resp_err;

    logic            w_unm_hit;
    logic            r_unm_err;
    logic            r_unm_blk;
    logic            w_kill;
    logic            w_to_err;

    // Round-robin pick: lowest requester above last, else lowest requester overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_pick  = '0;
        w_lo_pick  = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            w_hi_pick  = (s_wb_cyc[i] && (GW'(i) > r_last)) ? GW'(i) : w_hi_pick;
            w_hi_found = w_hi_found | (s_wb_cyc[i] && (GW'(i) > r_last));
            w_lo_pick  = s_wb_cyc[i] ? GW'(i) : w_lo_pick;
        end
        w_arb_found = |s_wb_cyc;
        w_arb_pick  = w_hi_found ? w_hi_pick : w_lo_pick;
    end

    // State register together with the grant and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= GW'(NM - 1);
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_arb_found) begin
                r_grant <= w_arb_pick;
                r_last  <= w_arb_pick;
            end
        end
    end

    // Next-state logic: a grant lasts exactly as long as the owner's cyc.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_arb_found ? ST_BUSY : ST_IDLE;
            ST_BUSY: w_state_nxt = w_g_cyc ? ST_BUSY : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_busy = (r_state == ST_BUSY);

    // Granted master's request, selected by AND-OR so no priority chain forms.
    always_comb begin
        w_g_adr = '0;
        w_g_sel = '0;
        w_g_we  = 1'b0;
        w_g_dat = '0;
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        for (int i = 0; i < NM; i++) begin
            w_g_adr = w_g_adr | ({AW{GW'(i) == r_grant}} & s_wb_adr[i*AW +: AW]);
            w_g_sel = w_g_sel | ({SW{GW'(i) == r_grant}} & s_wb_sel[i*SW +: SW]);
            w_g_dat = w_g_dat | ({DW{GW'(i) == r_grant}} & s_wb_dat_i[i*DW +: DW]);
            w_g_we  = w_g_we  | ((GW'(i) == r_grant) & s_wb_we[i]);
            w_g_cyc = w_g_cyc | ((GW'(i) == r_grant) & s_wb_cyc[i]);
            w_g_stb = w_g_stb | ((GW'(i) == r_grant) & s_wb_stb[i]);
        end
    end

    assign w_idx    = w_g_adr[AW-1:MSK];
    assign w_mapped = ({1'b0, w_idx} < NS_LIM);

    // Response of the decoded slave.
    always_comb begin
        w_sl_dat = '0;
        w_sl_ack = 1'b0;
        w_sl_err = 1'b0;
        for (int j = 0; j < NS; j++) begin
            w_sl_dat = w_sl_dat | ({DW{IW'(j) == w_idx}} & m_wb_dat_i[j*DW +: DW]);
            w_sl_ack = w_sl_ack | ((IW'(j) == w_idx) & m_wb_ack[j]);
            w_sl_err = w_sl_err | ((IW'(j) == w_idx) & m_wb_err[j]);
        end
    end

    // One err pulse per strobe to an unmapped slave; rearmed only once stb falls.
    assign w_unm_hit = w_busy & w_g_cyc & w_g_stb & ~w_mapped;

    // Unmapped-address error pulse and its rearm blocker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_unm_err <= 1'b0;
            r_unm_blk <= 1'b0;
        end else begin
            r_unm_err <= w_unm_hit & ~r_unm_blk;
            r_unm_blk <= w_unm_hit | (r_unm_blk & w_busy & w_g_stb);
        end
    end

`ifdef WB_ARB_XBAR_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_to_cnt;
    logic        r_to_err;
    logic        r_to_kill;
    logic        w_to_run;

    assign w_to_run = w_busy & w_g_cyc & w_g_stb & w_mapped & ~w_sl_ack & ~w_sl_err & ~r_to_kill;

    // Watchdog: counts unanswered strobe cycles, then errors and fences the slave until cyc ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= 16'd0;
            r_to_err  <= 1'b0;
            r_to_kill <= 1'b0;
        end else begin
            r_to_err <= w_to_run && (r_to_cnt == TO_LAST);
            if (!w_busy) begin
                r_to_kill <= 1'b0;
            end else if (w_to_run && (r_to_cnt == TO_LAST)) begin
                r_to_kill <= 1'b1;
            end
            if (!w_busy || !w_g_stb || w_sl_ack || w_sl_err || r_to_kill) begin
                r_to_cnt <= 16'd0;
            end else if (w_to_run) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign w_kill   = r_to_kill;
    assign w_to_err = r_to_err;
`else
    logic [15:0] w_unused_timeout;

    assign w_unused_timeout = 16'(TIMEOUT);
    assign w_kill           = 1'b0;
    assign w_to_err         = 1'b0;
`endif

    assign w_route    = w_busy & w_g_cyc & w_mapped & ~w_kill;
    assign w_fwd      = w_mapped & ~w_kill;
    assign w_resp_dat = w_fwd ? w_sl_dat : '0;
    assign w_resp_ack = w_fwd & w_sl_ack;
    assign w_resp_err = (w_fwd & w_sl_err) | r_unm_err | w_to_err;

    // Output routing: broadcast request to every slave, cyc/stb and responses only on the live path.
    always_comb begin
        s_wb_dat_o = '0;
        s_wb_ack   = '0;
        s_wb_err   = '0;
        m_wb_adr   = '0;
        m_wb_sel   = '0;
        m_wb_we    = '0;
        m_wb_dat_o = '0;
        m_wb_cyc   = '0;
        m_wb_stb   = '0;
        for (int i = 0; i < NM; i++) begin
            s_wb_dat_o[i*DW +: DW] = (w_busy && (GW'(i) == r_grant)) ? w_resp_dat : '0;
            s_wb_ack[i]            = w_busy && (GW'(i) == r_grant) && w_resp_ack;
            s_wb_err[i]            = w_busy && (GW'(i) == r_grant) && w_resp_err;
        end
        for (int j = 0; j < NS; j++) begin
            m_wb_adr[j*AW +: AW]   = w_busy ? w_g_adr : '0;
            m_wb_sel[j*SW +: SW]   = w_busy ? w_g_sel : '0;
            m_wb_dat_o[j*DW +: DW] = w_busy ? w_g_dat : '0;
            m_wb_we[j]             = w_busy & w_g_we;
            m_wb_cyc[j]            = w_route && (IW'(j) == w_idx);
            m_wb_stb[j]            = w_route && w_g_stb && (IW'(j) == w_idx);
        end
    end

endmodule

// File: doc/wb_arb_xbar.md
# wb_arb_xbar

Parametrised Wishbone interconnect that joins NM bus masters to NS slaves through one shared, arbitrated path, replacing the single-master crossbar in the FPGA top. A round-robin arbiter grants one master per bus cycle (held for the whole `cyc` burst). The block decodes the address top bits to a slave and returns a bus error for unmapped addresses. A watchdog terminates transfers that a slave never acknowledges.

## Interface
- `NM`, default 2: number of masters (1..8).
- `NS`, default 3: number of slaves (1..2^(AW-MSK)).
- `MSK`, default 24: slave index is `adr[AW-1:MSK]`.
- `AW`, default 32: address width.
- `DW`, default 128: data width; select width `SW = DW/8`.
- `TIMEOUT`, default 255: watchdog limit in cycles (1..65535).

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `s_wb_adr/_sel/_we/_dat_i/_cyc/_stb`  in  NM×{AW,SW,1,DW,1,1}  master-side requests, packed with master 0 at the LSBs.
- `s_wb_dat_o/_ack/_err`  out  NM×{DW,1,1}  master-side responses.
- `m_wb_adr/_sel/_we/_dat_o/_cyc/_stb`  out  NS×{AW,SW,1,DW,1,1}  slave-side requests, packed with slave 0 at the LSBs.
- `m_wb_dat_i/_ack/_err`  in  NS×{DW,1,1}  slave-side responses.

## Operation
- State machine: IDLE, BUSY.
- IDLE: if any `s_wb_cyc` is high, register a grant to the first requesting master after `last` (round-robin, wrapping), record `last`, and go to BUSY. Otherwise stay in IDLE.
- BUSY: the granted master's adr/sel/we/dat is routed to all slaves. `cyc` and `stb` go only to the decoded slave `idx = adr[AW-1:MSK]`.
  - The decoded slave's `dat_i/ack/err` is routed combinationally to the granted master.
  - When the granted master's `cyc` drops, return to IDLE at that edge. `stb` dropping alone keeps the grant.
- Non-granted masters see `dat_o=0`, `ack=0`, `err=0`. Non-selected slaves see `cyc=0`, `stb=0`. Broadcast adr/dat/sel/we are 0 in IDLE.
- Unmapped address (`idx >= NS`) while the granted master has `stb` high:
  - No slave is strobed.
  - `s_wb_err` of the granted master pulses for exactly one cycle, one cycle after `stb` is sampled.
  - The next pulse arms only after `stb` falls.
- A decode change mid-burst (new adr with `stb`) re-routes `cyc`/`stb` in the same cycle.
- Arbitration is non-preemptive; a request from another master waits until the current `cyc` ends.

## Timing
- Reset values: all `s_wb_ack/err/dat_o` = 0; all `m_wb_cyc/stb/adr/sel/we/dat_o` = 0. State is IDLE and `last = NM-1`, so master 0 has first priority.
- Arbitration latency: 1 cycle from `cyc` rising in IDLE to the routed `m_wb_cyc`.
- Ack path: 0 added cycles (combinational slave-to-master).
- Grant turnaround: at least one IDLE cycle between successive grants.
- Simultaneous requests in IDLE: the winner is the lowest index strictly after `last`, modulo NM.
- Reset asserted mid-transfer: the next edge forces IDLE, clears the grant and drops all slave-side `cyc`/`stb`. No ack is forwarded after that.

## Configuration
- `WB_ARB_XBAR_TIMEOUT_EN` defined:
  - A 16-bit counter clears on grant, on slave ack/err, and on `stb` low.
  - It increments while the granted `stb` is high to a mapped slave with no ack/err.
  - When the counter reaches TIMEOUT, the master gets a one-cycle `err` pulse. Slave `cyc`/`stb` are then forced low until the master drops `cyc`.
- `WB_ARB_XBAR_TIMEOUT_EN` undefined: no counter; a non-responding slave stalls the bus indefinitely.

## Test plan
- Reset, then master 0 reads adr 0x0100_0010 → slave 1 receives `cyc`/`stb` 1 cycle later. Slave acks with 0xA5…A5 → master 0 gets `ack` with the same data in the same cycle.
- Masters 0 and 1 raise `cyc` in the same cycle three times in a row → grants go 0, 1, 0, with one IDLE cycle between grants.
- Master 1 holds `cyc` across 4 strobed transfers while master 0 requests → master 0 is granted only after master 1's `cyc` falls.
- NS=3, master 0 accesses 0x0300_0000 → no `m_wb_stb` asserted; exactly one `err` pulse; no second pulse while `stb` stays high.
- With `WB_ARB_XBAR_TIMEOUT_EN` and TIMEOUT=8, slave 2 never acks → `err` reaches the master after 8 cycles of `stb`, and `m_wb_cyc[2]` drops.
- Assert `rst` mid-transfer with slave ack pending → all outputs are 0 next cycle; master 0 is highest priority afterwards.
